mem_bus_ctrl: RTL and testbench

- MEM-stage access controller: sequences each load/store from EX onto either the scratch-pad memory (SPM, zero-wait) or the shared system bus (request/grant/ready handshake).
- Raises busy to stall the pipeline while a bus access is pending.
- Returns read data to the MEM pipeline register.
- Sits between EX outputs and the MEM pipeline register; the bus side connects to the bus arbiter.

---
 rtl/mem_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// MEM-stage access controller: routes EX loads/stores to the zero-wait
// scratch-pad (SPM) or to the shared system bus. On the bus it runs a
// request/grant/ready handshake and raises busy while the access is pending.
module mem_bus_ctrl #(
  parameter int          ADDR_W     = 30,
  parameter int          DATA_W     = 32,
  parameter logic [2:0]  SPM_REGION = 3'h7
) (
  input  logic              clk,
  input  logic              reset,
  // EX side
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  // scratch-pad side (combinational)
  output logic              spm_as,
  output logic              spm_rw,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  // system bus side (registered)
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic                bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;

  logic spm_hit;

  // Top three address bits pick the scratch-pad region.
  assign spm_hit = (addr[ADDR_W-1:ADDR_W-3] == SPM_REGION);

  // SPM control follows EX directly; only the strobe is qualified.
  assign spm_rw      = rw;
  assign spm_addr    = addr;
  assign spm_wr_data = wr_data;

  assign bus_req     = bus_req_q;
  assign bus_as      = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

  // Next-state and output decode; bus_as defaults low so it pulses one cycle.
  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = 1'b0;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    rd_data       = '0;
    busy          = 1'b0;
    spm_as        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!flush && req) begin
          if (spm_hit) begin
            spm_as = 1'b1;
            if (rw) rd_data = spm_rd_data;
          end else begin
            busy      = 1'b1;
            bus_req_d = 1'b1;
            state_d   = REQ;
          end
        end
      end

      REQ: begin
        busy = 1'b1;
        // Once granted the access is committed, so grant beats flush.
        if (bus_grant) begin
          bus_as_d      = 1'b1;
          bus_rw_d      = rw;
          bus_addr_d    = addr;
          bus_wr_data_d = wr_data;
          state_d       = ACCESS;
        end else if (flush) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      ACCESS: begin
        // A started bus cycle always runs to completion; flush is ignored.
        busy = !bus_rdy;
        if (bus_rdy) begin
          if (bus_rw_q) rd_data = bus_rd_data;
          rd_buf_d  = bus_rd_data;
          bus_req_d = 1'b0;
          state_d   = stall ? STALL : IDLE;
        end
      end

      STALL: begin
        // Pipeline is frozen: keep presenting the captured load result.
        rd_data = rd_buf_q;
        if (!stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and bus-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_as_q      <= 1'b0;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: per-cycle vector table (inputs + expected outputs
// for that cycle), expected records queued on drive and popped at sample.
module tb_mem_bus_ctrl;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, req, rw, stall, flush;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data, spm_rd_data, bus_rd_data, spm_wr_data, bus_wr_data;
  logic          busy, spm_as, spm_rw, bus_req, bus_grant, bus_as, bus_rw, bus_rdy;
  logic [AW-1:0] spm_addr, bus_addr;

  mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SPM_REGION(3'h7)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr),
    .wr_data(wr_data), .stall(stall), .flush(flush), .rd_data(rd_data),
    .busy(busy), .spm_as(spm_as), .spm_rw(spm_rw), .spm_addr(spm_addr),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data), .bus_req(bus_req),
    .bus_grant(bus_grant), .bus_as(bus_as), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rdy(bus_rdy),
    .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst, req, rw, flush, stall, grant, rdy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, srd, brd;
  } in_t;

  typedef struct packed {
    logic [DW-1:0] rd_data;
    logic          busy, spm_as, bus_req, bus_as, bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wd;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string tag;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic in_t I(bit rst, bit rq, bit r, bit fl, bit st, bit g, bit rdy,
                            logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] srd,
                            logic [DW-1:0] brd);
    in_t v;
    v.rst = rst; v.req = rq; v.rw = r; v.flush = fl; v.stall = st;
    v.grant = g; v.rdy = rdy; v.addr = a; v.wd = wd; v.srd = srd; v.brd = brd;
    return v;
  endfunction

  function automatic out_t O(logic [DW-1:0] rd, bit bsy, bit sas, bit breq, bit bas,
                             bit brw, logic [AW-1:0] ba, logic [DW-1:0] bwd);
    out_t v;
    v.rd_data = rd; v.busy = bsy; v.spm_as = sas; v.bus_req = breq;
    v.bus_as = bas; v.bus_rw = brw; v.bus_addr = ba; v.bus_wd = bwd;
    return v;
  endfunction

  task automatic add(input in_t i, input out_t o, input string tag);
    vec_t v;
    v.i = i; v.o = o; v.tag = tag;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus, sample at the falling edge, then clock.
  task automatic apply(input in_t v, input out_t e, input string tag);
    out_t got, exp_v;
    reset = v.rst; req = v.req; rw = v.rw; flush = v.flush; stall = v.stall;
    bus_grant = v.grant; bus_rdy = v.rdy; addr = v.addr; wr_data = v.wd;
    spm_rd_data = v.srd; bus_rd_data = v.brd;
    exp_q.push_back(e);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got = O(rd_data, busy, spm_as, bus_req, bus_as, bus_rw, bus_addr, bus_wr_data);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got rd=%h busy=%b spm_as=%b breq=%b bas=%b brw=%b baddr=%h bwd=%h, want rd=%h busy=%b spm_as=%b breq=%b bas=%b brw=%b baddr=%h bwd=%h",
               tag, got.rd_data, got.busy, got.spm_as, got.bus_req, got.bus_as, got.bus_rw,
               got.bus_addr, got.bus_wd, exp_v.rd_data, exp_v.busy, exp_v.spm_as,
               exp_v.bus_req, exp_v.bus_as, exp_v.bus_rw, exp_v.bus_addr, exp_v.bus_wd);
    end
    checks++;
    if ({spm_rw, spm_addr, spm_wr_data} !== {v.rw, v.addr, v.wd}) begin
      errors++;
      $display("FAIL %s_spm_pass: got rw=%b addr=%h wd=%h, want rw=%b addr=%h wd=%h",
               tag, spm_rw, spm_addr, spm_wr_data, v.rw, v.addr, v.wd);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [AW-1:0] SA  = 30'h38000010;
  localparam logic [DW-1:0] DB  = 32'hDEADBEEF;
  localparam logic [DW-1:0] A5  = 32'hA5A5A5A5;
  localparam logic [DW-1:0] RD1 = 32'h12345678;
  localparam logic [DW-1:0] RD2 = 32'h87654321;

  initial begin
    //            rst rq rw fl st g  rdy addr          wd            srd           brd
    // reset state
    add(I(1, 0, 0, 0, 0, 0, 0, 30'h0,        32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h0,   32'h0), "reset");
    // SPM accesses in IDLE
    add(I(0, 1, 1, 0, 0, 0, 0, SA,           32'h0,        DB,           32'h0), O(DB,  0,1,0,0,1, 30'h0,   32'h0), "spm_rd");
    add(I(0, 1, 0, 0, 0, 0, 0, 30'h38000020, 32'h11112222, 32'hCAFEF00D, 32'h0), O(0,   0,1,0,0,1, 30'h0,   32'h0), "spm_wr");
    add(I(0, 0, 1, 0, 0, 0, 0, SA,           32'h0,        DB,           32'h0), O(0,   0,0,0,0,1, 30'h0,   32'h0), "idle_noreq");
    add(I(0, 1, 1, 1, 0, 0, 0, SA,           32'h0,        DB,           32'h0), O(0,   0,0,0,0,1, 30'h0,   32'h0), "flush_spm");
    add(I(0, 1, 1, 1, 0, 0, 0, 30'h100,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h0,   32'h0), "flush_bus");
    add(I(0, 0, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h0,   32'h0), "flush_bus_idle");
    // bus read: grant 2 cycles late, rdy 3 cycles after strobe
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,0,0,1, 30'h0,   32'h0), "brd_idle");
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,1,0,1, 30'h0,   32'h0), "brd_req0");
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,1,0,1, 30'h0,   32'h0), "brd_req1");
    add(I(0, 1, 1, 0, 0, 1, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,1,0,1, 30'h0,   32'h0), "brd_grant");
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,1,1,1, 30'h100, 32'h0), "brd_as");
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,1,0,1, 30'h100, 32'h0), "brd_wait1");
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   1,0,1,0,1, 30'h100, 32'h0), "brd_wait2");
    add(I(0, 1, 1, 0, 0, 0, 1, 30'h100,      32'h0,        32'h0,        RD1), O(RD1, 0,0,1,0,1, 30'h100, 32'h0), "brd_rdy");
    add(I(0, 0, 1, 0, 0, 1, 0, 30'h100,      32'h0,        32'h0,        RD1), O(0,   0,0,0,0,1, 30'h100, 32'h0), "brd_done");
    // bus write: immediate grant and rdy, busy exactly 2 cycles
    add(I(0, 1, 0, 0, 0, 0, 0, 30'h200,      A5,           32'h0,        32'h0), O(0,   1,0,0,0,1, 30'h100, 32'h0), "bwr_idle");
    add(I(0, 1, 0, 0, 0, 1, 0, 30'h200,      A5,           32'h0,        32'h0), O(0,   1,0,1,0,1, 30'h100, 32'h0), "bwr_grant");
    add(I(0, 0, 0, 0, 0, 0, 1, 30'h200,      32'h0,        32'h0,        32'hFFFF0000), O(0, 0,0,1,1,0, 30'h200, A5), "bwr_as_rdy");
    add(I(0, 0, 0, 0, 0, 0, 0, 30'h200,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,0, 30'h200, A5),    "bwr_done");
    // bus read ending under a 3-cycle stall; reqs in STALL are ignored
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h300,      32'h0,        32'h0,        32'h0), O(0,   1,0,0,0,0, 30'h200, A5),    "bst_idle");
    add(I(0, 1, 1, 0, 0, 1, 0, 30'h300,      32'h0,        32'h0,        32'h0), O(0,   1,0,1,0,0, 30'h200, A5),    "bst_grant");
    add(I(0, 1, 1, 0, 1, 0, 1, 30'h300,      32'h0,        32'h0,        RD2), O(RD2, 0,0,1,1,1, 30'h300, 32'h0), "bst_rdy");
    add(I(0, 1, 1, 0, 1, 0, 0, 30'h400,      32'h0,        32'h0,        32'h0), O(RD2, 0,0,0,0,1, 30'h300, 32'h0), "bst_stall1");
    add(I(0, 1, 1, 0, 1, 0, 0, SA,           32'h0,        DB,           32'h0), O(RD2, 0,0,0,0,1, 30'h300, 32'h0), "bst_stall2");
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h400,      32'h0,        32'h0,        32'h0), O(RD2, 0,0,0,0,1, 30'h300, 32'h0), "bst_stall3");
    add(I(0, 0, 1, 0, 0, 0, 0, 30'h400,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h300, 32'h0), "bst_idle2");
    // flush in REQ before grant drops the access
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h500,      32'h0,        32'h0,        32'h0), O(0,   1,0,0,0,1, 30'h300, 32'h0), "fl_idle");
    add(I(0, 1, 1, 1, 0, 0, 0, 30'h500,      32'h0,        32'h0,        32'h0), O(0,   1,0,1,0,1, 30'h300, 32'h0), "fl_req");
    add(I(0, 0, 1, 0, 0, 0, 0, 30'h500,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h300, 32'h0), "fl_dropped");
    add(I(0, 0, 1, 0, 0, 1, 1, 30'h500,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h300, 32'h0), "fl_stray_grant");
    add(I(0, 0, 1, 0, 0, 0, 0, 30'h500,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h300, 32'h0), "fl_no_as");
    // flush coincident with grant: grant wins, ACCESS ignores flush
    add(I(0, 1, 1, 0, 0, 0, 0, 30'h600,      32'h0,        32'h0,        32'h0), O(0,   1,0,0,0,1, 30'h300, 32'h0), "fg_idle");
    add(I(0, 1, 1, 1, 0, 1, 0, 30'h600,      32'h0,        32'h0,        32'h0), O(0,   1,0,1,0,1, 30'h300, 32'h0), "fg_grant");
    add(I(0, 1, 1, 1, 0, 0, 0, 30'h600,      32'h0,        32'h0,        32'h0BADF00D), O(0, 1,0,1,1,1, 30'h600, 32'h0), "fg_as");
    add(I(0, 1, 1, 0, 0, 0, 1, 30'h600,      32'h0,        32'h0,        32'h0BADF00D), O(32'h0BADF00D, 0,0,1,0,1, 30'h600, 32'h0), "fg_rdy");
    add(I(0, 0, 1, 0, 0, 0, 0, 30'h600,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h600, 32'h0), "fg_done");
    // reset while in ACCESS
    add(I(0, 1, 0, 0, 0, 0, 0, 30'h700,      32'h55AA55AA, 32'h0,        32'h0), O(0,   1,0,0,0,1, 30'h600, 32'h0), "rst_idle");
    add(I(0, 1, 0, 0, 0, 1, 0, 30'h700,      32'h55AA55AA, 32'h0,        32'h0), O(0,   1,0,1,0,1, 30'h600, 32'h0), "rst_grant");
    add(I(1, 1, 0, 0, 0, 0, 0, 30'h700,      32'h55AA55AA, 32'h0,        32'h0), O(0,   1,0,1,1,0, 30'h700, 32'h55AA55AA), "rst_access");
    add(I(0, 0, 1, 0, 0, 0, 0, 30'h700,      32'h0,        32'h0,        32'h0), O(0,   0,0,0,0,1, 30'h0,   32'h0), "rst_after");

    // Bring the DUT out of its unknown power-up state first.
    reset = 1'b1; req = 1'b0; rw = 1'b1; flush = 1'b0; stall = 1'b0;
    bus_grant = 1'b0; bus_rdy = 1'b0; addr = '0; wr_data = '0;
    spm_rd_data = '0; bus_rd_data = '0;
    @(posedge clk);
    #1;

    foreach (tbl[k]) apply(tbl[k].i, tbl[k].o, tbl[k].tag);

    // Randomized SPM traffic back-to-back from IDLE (bus regs are at reset values).
    for (int n = 0; n < 20; n++) begin
      in_t           v;
      logic [26:0]   low;
      low = 27'($urandom);
      v = I(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0,
            {3'h7, low}, $urandom, $urandom, $urandom);
      apply(v, O((v.req && v.rw) ? v.srd : 32'h0, 0, v.req, 0, 0, 1, 30'h0, 32'h0),
            $sformatf("spm_rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
